router_fsm: RTL and testbench

Control state machine for the 1x3 router. It sequences the packet register (`router_register`) and the write side of the three output FIFOs, one packet at a time. It decodes the header address and holds off while the target FIFO is non-empty or full. It drives the per-state strobes that tell the register when to latch the header, payload and parity, and when to clear its internal parity state.

---
 rtl/router_pkg.sv | 24 ++
 rtl/router_fsm.sv | 140 ++++++++++++++
 tb/tb_router_fsm.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared state encoding for the 1x3 router control FSM.
package router_pkg;

   localparam logic [2:0] S_DECODE_ADDRESS     = 3'd0;
   localparam logic [2:0] S_LOAD_FIRST_DATA    = 3'd1;
   localparam logic [2:0] S_LOAD_DATA          = 3'd2;
   localparam logic [2:0] S_FIFO_FULL_STATE    = 3'd3;
   localparam logic [2:0] S_LOAD_AFTER_FULL    = 3'd4;
   localparam logic [2:0] S_LOAD_PARITY        = 3'd5;
   localparam logic [2:0] S_CHECK_PARITY_ERROR = 3'd6;
   localparam logic [2:0] S_WAIT_TILL_EMPTY    = 3'd7;

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = S_DECODE_ADDRESS,
      LOAD_FIRST_DATA    = S_LOAD_FIRST_DATA,
      LOAD_DATA          = S_LOAD_DATA,
      FIFO_FULL_STATE    = S_FIFO_FULL_STATE,
      LOAD_AFTER_FULL    = S_LOAD_AFTER_FULL,
      LOAD_PARITY        = S_LOAD_PARITY,
      CHECK_PARITY_ERROR = S_CHECK_PARITY_ERROR,
      WAIT_TILL_EMPTY    = S_WAIT_TILL_EMPTY
   } state_e;

endpackage

// File: rtl/router_fsm.sv
// Router control FSM: sequences the packet register and FIFO writes,
// one packet at a time, with per-state strobes as Moore outputs.
module router_fsm
   import router_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       packet_valid,
   input  logic [1:0] datain,
   input  logic       fifo_full,
   input  logic       fifo_empty_0,
   input  logic       fifo_empty_1,
   input  logic       fifo_empty_2,
   input  logic       soft_reset_0,
   input  logic       soft_reset_1,
   input  logic       soft_reset_2,
   input  logic       parity_done,
   input  logic       low_packet_valid,
   output logic       write_enb_reg,
   output logic       detect_add,
   output logic       lfd_state,
   output logic       ld_state,
   output logic       laf_state,
   output logic       full_state,
   output logic       rst_int_reg,
   output logic       busy
);

   state_e     state_q, state_d;
   logic [1:0] addr_q, addr_d;
   logic       hdr_empty;
   logic       sel_empty;
   logic       sel_soft;

   // Empty flag of the FIFO named by the incoming header
   always_comb begin
      hdr_empty = 1'b0;
      unique case (datain)
         2'd0:    hdr_empty = fifo_empty_0;
         2'd1:    hdr_empty = fifo_empty_1;
         2'd2:    hdr_empty = fifo_empty_2;
         default: hdr_empty = 1'b0;
      endcase
   end

   always_comb begin
      sel_empty = 1'b0;
      sel_soft  = 1'b0;
      unique case (addr_q)
         2'd0: begin
            sel_empty = fifo_empty_0;
            sel_soft  = soft_reset_0;
         end
         2'd1: begin
            sel_empty = fifo_empty_1;
            sel_soft  = soft_reset_1;
         end
         2'd2: begin
            sel_empty = fifo_empty_2;
            sel_soft  = soft_reset_2;
         end
         default: begin
            sel_empty = 1'b0;
            sel_soft  = 1'b0;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      unique case (state_q)
         DECODE_ADDRESS: begin
            if (packet_valid) begin
               addr_d = datain;
            end
            if (packet_valid && datain != 2'd3) begin
               state_d = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
         end
         LOAD_FIRST_DATA: state_d = LOAD_DATA;
         LOAD_DATA: begin
            if (fifo_full) begin
               state_d = FIFO_FULL_STATE;
            end else if (!packet_valid) begin
               state_d = LOAD_PARITY;
            end
         end
         FIFO_FULL_STATE: begin
            if (!fifo_full) begin
               state_d = LOAD_AFTER_FULL;
            end
         end
         LOAD_AFTER_FULL: begin
            if (parity_done) begin
               state_d = DECODE_ADDRESS;
            end else if (low_packet_valid) begin
               state_d = LOAD_PARITY;
            end else begin
               state_d = LOAD_DATA;
            end
         end
         LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
         CHECK_PARITY_ERROR: begin
            state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
         end
         WAIT_TILL_EMPTY: begin
            if (sel_empty) begin
               state_d = LOAD_FIRST_DATA;
            end
         end
         default: state_d = DECODE_ADDRESS;
      endcase
      // A read timeout on the selected FIFO abandons the packet
      if (state_q != DECODE_ADDRESS && sel_soft) begin
         state_d = DECODE_ADDRESS;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= DECODE_ADDRESS;
         addr_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   assign detect_add    = (state_q == DECODE_ADDRESS);
   assign lfd_state     = (state_q == LOAD_FIRST_DATA);
   assign ld_state      = (state_q == LOAD_DATA);
   assign full_state    = (state_q == FIFO_FULL_STATE);
   assign laf_state     = (state_q == LOAD_AFTER_FULL);
   assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
   assign write_enb_reg = ld_state | laf_state
                        | (state_q == LOAD_PARITY);
   assign busy          = !(detect_add | ld_state);

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: checks the state strobes cycle by cycle
// against hand-written per-state output patterns.
module tb_router_fsm;
   import router_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       packet_valid;
   logic [1:0] datain;
   logic       fifo_full;
   logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
   logic       soft_reset_0, soft_reset_1, soft_reset_2;
   logic       parity_done;
   logic       low_packet_valid;
   logic       write_enb_reg, detect_add, lfd_state, ld_state;
   logic       laf_state, full_state, rst_int_reg, busy;

   int n_chk  = 0;
   int n_fail = 0;
   int we_cnt;
   int rst_cnt;

   router_fsm dut (
      .clk              (clk),
      .reset            (reset),
      .packet_valid     (packet_valid),
      .datain           (datain),
      .fifo_full        (fifo_full),
      .fifo_empty_0     (fifo_empty_0),
      .fifo_empty_1     (fifo_empty_1),
      .fifo_empty_2     (fifo_empty_2),
      .soft_reset_0     (soft_reset_0),
      .soft_reset_1     (soft_reset_1),
      .soft_reset_2     (soft_reset_2),
      .parity_done      (parity_done),
      .low_packet_valid (low_packet_valid),
      .write_enb_reg    (write_enb_reg),
      .detect_add       (detect_add),
      .lfd_state        (lfd_state),
      .ld_state         (ld_state),
      .laf_state        (laf_state),
      .full_state       (full_state),
      .rst_int_reg      (rst_int_reg),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   // {detect_add,lfd,ld,laf,full,rst_int,write_enb,busy}
   function automatic logic [7:0] pat(input logic [2:0] s);
      case (s)
         S_DECODE_ADDRESS:     pat = 8'b1000_0000;
         S_LOAD_FIRST_DATA:    pat = 8'b0100_0001;
         S_LOAD_DATA:          pat = 8'b0010_0010;
         S_LOAD_AFTER_FULL:    pat = 8'b0001_0011;
         S_FIFO_FULL_STATE:    pat = 8'b0000_1001;
         S_CHECK_PARITY_ERROR: pat = 8'b0000_0101;
         S_LOAD_PARITY:        pat = 8'b0000_0011;
         default:              pat = 8'b0000_0001;
      endcase
   endfunction

   function automatic logic [7:0] obs();
      obs = {detect_add, lfd_state, ld_state, laf_state,
             full_state, rst_int_reg, write_enb_reg, busy};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      we_cnt  += int'(write_enb_reg);
      rst_cnt += int'(rst_int_reg);
   endtask

   task automatic st(input string tag, input logic [2:0] s);
      chk(tag, {24'd0, obs()}, {24'd0, pat(s)});
   endtask

   initial begin
      reset = 1'b1;
      packet_valid = 1'b0;
      datain = 2'd0;
      fifo_full = 1'b0;
      fifo_empty_0 = 1'b1;
      fifo_empty_1 = 1'b1;
      fifo_empty_2 = 1'b1;
      soft_reset_0 = 1'b0;
      soft_reset_1 = 1'b0;
      soft_reset_2 = 1'b0;
      parity_done = 1'b0;
      low_packet_valid = 1'b0;
      we_cnt = 0;
      rst_cnt = 0;

      tick();
      st("reset", S_DECODE_ADDRESS);
      reset = 1'b0;
      tick();
      st("idle", S_DECODE_ADDRESS);

      // good packet, header 8'h3A -> addr 2, 14 payload bytes
      packet_valid = 1'b1;
      datain = 2'd2;
      tick();
      st("hdr_lfd", S_LOAD_FIRST_DATA);
      we_cnt = 0;
      rst_cnt = 0;
      tick();
      for (int i = 1; i <= 14; i++) begin
         st($sformatf("ld%0d", i), S_LOAD_DATA);
         if (i == 14) packet_valid = 1'b0;
         tick();
      end
      st("parity", S_LOAD_PARITY);
      tick();
      st("chk_par", S_CHECK_PARITY_ERROR);
      tick();
      st("done", S_DECODE_ADDRESS);
      chk("we_cycles", we_cnt, 15);
      chk("rst_pulses", rst_cnt, 1);

      // address 3 is not a valid port
      packet_valid = 1'b1;
      datain = 2'd3;
      tick();
      st("addr3", S_DECODE_ADDRESS);

      // addr 1 with FIFO 1 occupied; wait must use latched address
      datain = 2'd1;
      fifo_empty_1 = 1'b0;
      tick();
      st("wait", S_WAIT_TILL_EMPTY);
      packet_valid = 1'b0;
      datain = 2'd0;
      tick();
      st("wait2", S_WAIT_TILL_EMPTY);
      fifo_empty_1 = 1'b1;
      packet_valid = 1'b1;
      tick();
      st("wait_lfd", S_LOAD_FIRST_DATA);
      tick();
      for (int i = 1; i <= 4; i++) tick();
      st("ld5", S_LOAD_DATA);
      fifo_full = 1'b1;
      tick();
      st("full", S_FIFO_FULL_STATE);
      packet_valid = 1'b0;
      tick();
      st("full_hold", S_FIFO_FULL_STATE);
      fifo_full = 1'b0;
      tick();
      st("laf", S_LOAD_AFTER_FULL);
      low_packet_valid = 1'b1;
      tick();
      st("laf_par", S_LOAD_PARITY);
      low_packet_valid = 1'b0;
      tick();
      st("laf_chk", S_CHECK_PARITY_ERROR);
      tick();
      st("laf_done", S_DECODE_ADDRESS);

      // full with pv low at same edge; laf back to ld; parity_done exit
      packet_valid = 1'b1;
      datain = 2'd0;
      tick();
      tick();
      st("p3_ld", S_LOAD_DATA);
      fifo_full = 1'b1;
      packet_valid = 1'b0;
      tick();
      st("full_pri", S_FIFO_FULL_STATE);
      fifo_full = 1'b0;
      tick();
      st("laf2", S_LOAD_AFTER_FULL);
      packet_valid = 1'b1;
      tick();
      st("laf_ld", S_LOAD_DATA);
      packet_valid = 1'b0;
      tick();
      st("p3_par", S_LOAD_PARITY);
      fifo_full = 1'b1;
      tick();
      st("p3_chk", S_CHECK_PARITY_ERROR);
      tick();
      st("chk_full", S_FIFO_FULL_STATE);
      fifo_full = 1'b0;
      tick();
      st("laf3", S_LOAD_AFTER_FULL);
      parity_done = 1'b1;
      tick();
      st("pdone", S_DECODE_ADDRESS);
      parity_done = 1'b0;

      // soft resets while loading addr 0
      packet_valid = 1'b1;
      datain = 2'd0;
      tick();
      tick();
      st("sr_ld", S_LOAD_DATA);
      soft_reset_1 = 1'b1;
      tick();
      st("sr1_ign", S_LOAD_DATA);
      soft_reset_1 = 1'b0;
      soft_reset_0 = 1'b1;
      packet_valid = 1'b0;
      tick();
      st("sr0", S_DECODE_ADDRESS);
      soft_reset_0 = 1'b0;

      // hard reset while stalled on a full FIFO
      packet_valid = 1'b1;
      tick();
      tick();
      fifo_full = 1'b1;
      tick();
      st("rst_full", S_FIFO_FULL_STATE);
      reset = 1'b1;
      tick();
      st("rst_mid", S_DECODE_ADDRESS);
      reset = 1'b0;
      fifo_full = 1'b0;
      packet_valid = 1'b0;
      tick();
      st("post_rst", S_DECODE_ADDRESS);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
